// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester, response and RAM port bundle for the SRAM port arbiter
interface sram_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int WORD_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_wren;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [WORD_WIDTH-1:0]         rsp_data;
   logic                          ram_wren;
   logic [ADDR_WIDTH-1:0]         ram_addr;
   logic [WORD_WIDTH-1:0]         ram_write_data;
   logic [WORD_WIDTH-1:0]         ram_read_data;

   // Requesters plus the RAM macro, as seen from outside the arbiter
   modport master (
      output req_valid, req_last, req_wren, req_addr, req_wdata, ram_read_data,
      input  req_ready, rsp_valid, rsp_data, ram_wren, ram_addr, ram_write_data
   );

   // The arbiter itself
   modport slave (
      input  req_valid, req_last, req_wren, req_addr, req_wdata, ram_read_data,
      output req_ready, rsp_valid, rsp_data, ram_wren, ram_addr, ram_write_data
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin burst arbiter sharing one single-port RAM among requesters
module sram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WORD_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int BURST_MAX  = 4
) (
   input logic                clk,
   input logic                rst,
   sram_port_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [NUM_REQ-1:0]   rsp_sel_q, rsp_sel_d;

   logic [IW-1:0]        grant;
   logic                 granted;
   logic                 accept;
   logic [NUM_REQ-1:0]   ready;
   logic                 ram_wren;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WORD_WIDTH-1:0] ram_wdata;
   int                   idx;
   int                   beats;

   // Grant selection, RAM port drive and next-state computation for the lock/pointer/response
   always_comb begin
      grant     = owner_q;
      granted   = 1'b0;
      idx       = 0;
      beats     = 0;
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      rsp_sel_d = '0;

      if (state_q == IDLE) begin
         // Walk offsets from the far end so the nearest valid requester above the pointer wins last
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
               granted = 1'b1;
               grant   = IW'(idx);
            end
         end
      end else begin
         // The owner keeps the port even while it is not offering a beat
         granted = 1'b1;
      end

      ready  = granted ? (NUM_REQ'(1) << grant) : '0;
      accept = granted & bus.req_valid[grant];

      ram_wren  = accept & bus.req_wren[grant];
      ram_addr  = accept ? bus.req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      ram_wdata = accept ? bus.req_wdata[int'(grant)*WORD_WIDTH +: WORD_WIDTH] : '0;

      if (accept) begin
         beats = (state_q == IDLE) ? 1 : int'(count_q) + 1;
         if (bus.req_last[grant] || beats >= BURST_MAX) begin
            state_d = IDLE;
            ptr_d   = IW'((int'(grant) + 1) % NUM_REQ);
            count_d = '0;
         end else begin
            state_d = BURST;
            owner_d = grant;
            count_d = CW'(beats);
         end
         if (!bus.req_wren[grant]) begin
            rsp_sel_d = NUM_REQ'(1) << grant;
         end
      end
   end

   // Arbitration state and the one-deep read response tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         count_q   <= '0;
         rsp_sel_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         rsp_sel_q <= rsp_sel_d;
      end
   end

   assign bus.req_ready      = ready;
   assign bus.ram_wren       = ram_wren;
   assign bus.ram_addr       = ram_addr;
   assign bus.ram_write_data = ram_wdata;
   assign bus.rsp_valid      = rsp_sel_q;
   assign bus.rsp_data       = bus.ram_read_data;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed scoreboard bench for the SRAM port arbiter
module tb_sram_port_arbiter;
   localparam int NR = 4;
   localparam int WW = 8;
   localparam int AW = 8;
   localparam int BM = 4;

   typedef struct {
      int            due;
      logic [NR-1:0] sel;
      logic [WW-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init = 1'b1;
   bit   mon_en = 1'b0;
   int   cycle = 0;
   int   checks = 0;
   int   errors = 0;
   rsp_t sb[$];
   rsp_t mon_e;
   logic [WW-1:0] mem [0:255];
   logic [WW-1:0] exp_mem [0:255];

   always #5 clk = ~clk;

   sram_port_arbiter_if #(.NUM_REQ(NR), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

   sram_port_arbiter #(.NUM_REQ(NR), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .BURST_MAX(BM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Single-port RAM with registered read
   always @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         bus.ram_read_data <= '0;
      end else begin
         if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_write_data;
         bus.ram_read_data <= mem[bus.ram_addr];
      end
   end

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops the scoreboard when an issued read is due, otherwise expects silence
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].due == cycle) begin
            mon_e = sb.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(mon_e.sel));
            chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
         end else begin
            chk("rsp_idle", 32'(bus.rsp_valid), 32'(0));
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic l, input logic w,
                          input logic [AW-1:0] a, input logic [WW-1:0] d);
      bus.req_valid[i]          = v;
      bus.req_last[i]           = l;
      bus.req_wren[i]           = w;
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_wdata[i*WW +: WW] = d;
   endtask

   task automatic clr_all();
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_wren  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   // One cycle: check grant and RAM drive, record the expected effect, advance past the edge
   task automatic step(input string tag, input logic [NR-1:0] exp_ready);
      logic [NR-1:0] acc;
      int            g;
      logic [AW-1:0] a;
      logic [WW-1:0] d;
      rsp_t          e;
      @(negedge clk);
      chk({tag, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
      acc = exp_ready & bus.req_valid;
      if (acc != '0) begin
         g = 0;
         for (int i = 0; i < NR; i++) if (acc[i]) g = i;
         a = bus.req_addr[g*AW +: AW];
         d = bus.req_wdata[g*WW +: WW];
         chk({tag, " ram_wren"}, 32'(bus.ram_wren), 32'(bus.req_wren[g]));
         chk({tag, " ram_addr"}, 32'(bus.ram_addr), 32'(a));
         chk({tag, " ram_wdata"}, 32'(bus.ram_write_data), 32'(d));
         if (bus.req_wren[g]) begin
            exp_mem[a] = d;
         end else begin
            e.due  = cycle + 1;
            e.sel  = NR'(1) << g;
            e.data = exp_mem[a];
            sb.push_back(e);
         end
      end else begin
         chk({tag, " ram_wren idle"}, 32'(bus.ram_wren), 32'(0));
         chk({tag, " ram_addr idle"}, 32'(bus.ram_addr), 32'(0));
         chk({tag, " ram_wdata idle"}, 32'(bus.ram_write_data), 32'(0));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
      clr_all();
      #1;
      chk("reset req_ready", 32'(bus.req_ready), 32'(0));
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'(0));
      chk("reset ram_wren", 32'(bus.ram_wren), 32'(0));
      chk("reset ram_addr", 32'(bus.ram_addr), 32'(0));
      chk("reset ram_wdata", 32'(bus.ram_write_data), 32'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      init   = 1'b0;
      rst    = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Basic write then read by requester 2
      set_req(2, 1, 1, 1, 8'h10, 8'hA5);
      step("basic_wr", 4'b0100);
      set_req(2, 1, 1, 0, 8'h10, 8'h00);
      step("basic_rd", 4'b0100);
      clr_all();
      step("basic_idle", 4'b0000);

      // Bring the pointer back to 0
      set_req(3, 1, 1, 0, 8'h13, 8'h00);
      step("prep_r3", 4'b1000);

      // Fairness: everyone valid, single-beat grants rotate with no bubbles
      for (int i = 0; i < NR; i++) set_req(i, 1, 1, 0, AW'(8'h10 + i), 8'h00);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) step("fair", NR'(1) << i);
      end
      clr_all();

      // Burst cap: requester 1 streams, requester 3 gets in after four beats
      set_req(3, 1, 1, 0, 8'h23, 8'h00);
      for (int k = 0; k < BM; k++) begin
         set_req(1, 1, 0, 1, AW'(8'h20 + k), WW'(8'h30 + k));
         step("cap_r1", 4'b0010);
      end
      set_req(1, 1, 0, 1, 8'h24, 8'h34);
      step("cap_r3", 4'b1000);
      set_req(3, 0, 0, 0, 8'h00, 8'h00);
      step("cap_r1_again", 4'b0010);
      set_req(1, 1, 1, 1, 8'h25, 8'h35);
      step("cap_r1_last", 4'b0010);
      clr_all();

      // Burst lock: owner 0 pauses, requester 2 stays locked out
      set_req(0, 1, 0, 1, 8'h30, 8'h5A);
      step("lock_start", 4'b0001);
      set_req(0, 0, 0, 0, 8'h00, 8'h00);
      set_req(2, 1, 1, 0, 8'h20, 8'h00);
      for (int k = 0; k < 3; k++) step("lock_hold", 4'b0001);
      set_req(0, 1, 1, 0, 8'h30, 8'h00);
      step("lock_resume", 4'b0001);
      set_req(0, 0, 0, 0, 8'h00, 8'h00);
      step("lock_r2", 4'b0100);
      clr_all();

      // Reset in the middle of a burst with a read response in flight
      set_req(1, 1, 0, 0, 8'h21, 8'h00);
      step("rst_rd", 4'b0010);
      chk("pre_rst rsp_valid", 32'(bus.rsp_valid), 32'(4'b0010));
      rst = 1'b1;
      #1;
      chk("in_rst rsp_valid", 32'(bus.rsp_valid), 32'(0));
      sb.delete();
      clr_all();
      #1;
      rst = 1'b0;
      set_req(0, 1, 1, 0, 8'h10, 8'h00);
      set_req(1, 1, 1, 0, 8'h11, 8'h00);
      step("post_rst r0", 4'b0001);
      step("post_rst r1", 4'b0010);
      clr_all();

      // Interleaved reads of two words by two requesters
      set_req(0, 1, 1, 1, 8'h40, 8'h11);
      step("il_wr0", 4'b0001);
      clr_all();
      set_req(1, 1, 1, 1, 8'h41, 8'h22);
      step("il_wr1", 4'b0010);
      set_req(0, 1, 1, 0, 8'h40, 8'h00);
      set_req(1, 1, 1, 0, 8'h41, 8'h00);
      for (int k = 0; k < 2; k++) begin
         step("il_rd0", 4'b0001);
         step("il_rd1", 4'b0010);
      end
      clr_all();
      step("drain", 4'b0000);
      step("drain", 4'b0000);
      chk("scoreboard empty", 32'(sb.size()), 32'(0));

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter that shares one single-port RAM instance (1-cycle registered read, old-data-on-collision) among NUM_REQ requesters inside the switch packet buffer. It accepts read/write beats over per-requester valid/ready handshakes, drives the RAM port directly, and routes each read result back to its issuer one cycle after issue. Requesters can hold the port for bounded bursts.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WORD_WIDTH, 8: RAM word width.
- ADDR_WIDTH, 8: RAM address width.
- BURST_MAX, 4: maximum beats per grant, 1..16.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  beat offered by requester i.
- req_last  in  NUM_REQ  offered beat ends requester i's burst.
- req_wren  in  NUM_REQ  1 = write beat, 0 = read beat.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WORD_WIDTH  per-requester write data, same slicing.
- req_ready  out  NUM_REQ  one-hot or zero; beat accepted when valid & ready.
- rsp_valid  out  NUM_REQ  one-hot; read data for requester i is valid.
- rsp_data  out  WORD_WIDTH  shared read data.
- ram_wren, ram_addr, ram_write_data  out  1/ADDR_WIDTH/WORD_WIDTH  to RAM.
- ram_read_data  in  WORD_WIDTH  from RAM.

## Operation
- States: IDLE (no owner), BURST (owner locked). Registers: state, owner index, rr pointer, beat counter, rsp_sel (one-hot).
- IDLE: grant = first i with req_valid[i], scanning from pointer upward, wrapping at NUM_REQ. req_ready[grant] = 1 combinationally in the same cycle; all others 0. With no valid, req_ready = 0.
- Accepted beat in IDLE: if req_last = 1 or BURST_MAX = 1, the grant ends, pointer <= grant+1 mod NUM_REQ, and the state stays IDLE. Otherwise owner <= grant, count <= 1, and the state goes to BURST.
- BURST: req_ready[owner] = 1; all others 0. If the owner drops valid, the lock holds and other requesters are not served.
- Each accepted beat increments count. A beat with req_last = 1, or the beat that brings count to BURST_MAX, ends the grant: pointer <= owner+1 mod NUM_REQ, and the next state is IDLE.
- The RAM port is combinational from the accepted beat: ram_wren = accept & req_wren[g], ram_addr = req_addr[g], ram_write_data = req_wdata[g].
- With no accepted beat, ram_wren, ram_addr and ram_write_data are all 0.
- An accepted read beat sets rsp_sel <= onehot(g); any other cycle clears it. rsp_valid = rsp_sel, and rsp_data = ram_read_data.
- Write beats produce no response.
- Read-after-write to the same address on consecutive beats returns the written data. The RAM registers old data only on the same-cycle collision, and a single port cannot produce one.

## Timing
- Reset values: state IDLE, pointer 0, count 0, rsp_sel 0. Outputs: req_ready 0, rsp_valid 0, ram_wren 0, ram_addr 0, ram_write_data 0.
- Arbitration has zero latency: with valid in cycle N, the beat can be accepted in cycle N.
- Back-to-back beats cost no bubbles, including across grant changes.
- Read latency: accepted in cycle N, rsp_valid and data in cycle N+1. One read response is outstanding per cycle, and responses always return in issue order.
- Reset is asynchronous: it clears mid-burst ownership and drops any pending response. The first arbitration after reset release starts from requester 0.
- No combinational path from ram_read_data to req_ready.

## Test plan
- **Basic write/read:** write 0xA5 to addr 0x10 via requester 2, then read it back. Requires ram_wren pulse at the write, and rsp_valid = 4'b0100 with rsp_data = 0xA5 one cycle after the read accept.
- **Fairness:** all four requesters hold valid with last = 1 continuously. Grants must be 0,1,2,3,0,… with one beat per cycle and no idle cycles.
- **Burst cap:** with BURST_MAX = 4, requester 1 streams 6 beats with last = 0 while requester 3 is valid. Requires beats 1-4 from requester 1, then requester 3, then requester 1 again.
- **Burst lock:** requester 0 starts a burst, then drops valid for 3 cycles while requester 2 is valid. Requires req_ready = 0 to requester 2 throughout, and the grant resumes to requester 0 on its next valid.
- **Reset mid-burst:** assert reset one cycle after requester 1 issues a read in a burst. Requires rsp_valid = 0 immediately, and after release requester 0 (pointer 0) wins a 0-vs-1 contention.
- **Interleaved reads:** requesters 0 and 1 alternate reads to addresses holding 0x11 and 0x22. Each rsp_valid bit must match its issuer with the correct data, one cycle late.
